instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage for the 16-bit RISC core. Owns the program counter, issues one-at-a-time reads to instruction memory over a req/ack handshake, and buffers returned instructions in a small prefetch FIFO. It presents `{pc, instruction}` to the decode/control stage, which derives `op_code` and the control wires (`jump`, `beq`, `bne`, `alu_op`, …). It accepts PC redirects from the branch/jump logic and discards wrong-path fetches.

## Interface
- `PC_WIDTH`, 16, width of PC and instruction-memory address (byte address).
- `FIFO_DEPTH`, 2, prefetch entries; legal values 2 or 4.
- `RESET_PC`, 16'h0000, first fetch address after reset.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req`  out  1  read request. Held high until `imem_ack`.
- `imem_addr`  out  PC_WIDTH  read address. Stable while `imem_req` is high.
- `imem_ack`  in  1  completes the request. Sampled only when `imem_req` is high. May be high in the same cycle `imem_req` rises.
- `imem_rdata`  in  16  instruction word; valid only in the `imem_ack` cycle.
- `redirect`  in  1  one-cycle pulse: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  PC_WIDTH  new fetch address; must be even.
- `if_valid`  out  1  FIFO head is valid.
- `if_ready`  in  1  decode accepts the head; transfer occurs when `if_valid && if_ready`.
- `if_instr`  out  16  head instruction.
- `if_op_code`  out  4  `if_instr[15:12]`, combinational.
- `if_pc`  out  PC_WIDTH  address of the head instruction.

## Operation
- **PC rule:** `fetch_pc` is the next address to request. It advances by 2 per accepted (non-discarded) ack and wraps modulo 2^PC_WIDTH (0xFFFE → 0x0000).
- **FIFO:** entries are `{pc, instr}`; `count` runs 0..FIFO_DEPTH. Push and pop in the same cycle are legal when full, because the pop frees the slot.
- **Space rule:** a new request may be issued only if `count_next < FIFO_DEPTH`. Because one request is outstanding at most, this guarantees the returned word always has a slot.
- **State machine:**
  - **IDLE:** `imem_req` = 0.
    - If `redirect`: flush FIFO, `fetch_pc` ← `redirect_pc`, then go to WAIT.
    - Else if there is space: go to WAIT.
    - In both cases the registered `imem_addr` ← the resulting `fetch_pc`.
  - **WAIT:** `imem_req` = 1.
    - Ack without redirect: push `{imem_addr, imem_rdata}`, `fetch_pc` += 2. Stay in WAIT with `imem_addr` = new `fetch_pc` if there is still space; otherwise go to IDLE. Back-to-back requests are allowed.
    - Redirect without ack: flush FIFO, `fetch_pc` ← `redirect_pc`, go to DISCARD. `imem_req` and `imem_addr` stay unchanged, since a request is never withdrawn.
    - Redirect with ack in the same cycle: drop `imem_rdata`, flush, stay in WAIT with `imem_addr` ← `redirect_pc`.
  - **DISCARD:** `imem_req` = 1 on the stale address.
    - Ack: drop the data, go to WAIT with `imem_addr` ← `fetch_pc`.
    - Further redirect: `fetch_pc` ← `redirect_pc`, flush, stay in DISCARD. If ack arrives in the same cycle, go to WAIT at `redirect_pc`.
- **Redirect priority:** redirect wins over a simultaneous pop. The popped entry is still considered consumed by decode, and the FIFO ends empty.
- **Reset** (any time, including mid-request):
  - State IDLE, `count` = 0, `fetch_pc` = `RESET_PC`.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0.
  - Any in-flight memory response is abandoned; memory must tolerate `imem_req` dropping without ack on reset.

## Timing
- After `rst` deasserts, `imem_req` rises at the first rising edge, with `imem_addr` = `RESET_PC`.
- Ack in cycle N → `if_valid` high in cycle N+1 with that word. Fetch latency = memory latency + 1.
- With zero-wait memory (`imem_ack` tied high) and `if_ready` held high, sustained throughput is 1 instruction/cycle.
- Redirect in cycle N with no request outstanding → `imem_req`/`imem_addr` = `redirect_pc` in cycle N+1.
- `if_valid` falls in cycle N+1 after a redirect in cycle N.
- All outputs are registered except `if_op_code`.

## Test plan
- **Reset, sequential fetch:** memory returns `instr = addr ^ 16'hA5A5` with 0 wait, `if_ready` = 1 → `if_pc` sequence 0x0000, 0x0002, 0x0004… one per cycle starting 2 cycles after reset release; `if_op_code` matches bits [15:12].
- **Backpressure:** `if_ready` = 0 from the start, 0-wait memory → exactly FIFO_DEPTH words fetched (0x0000, 0x0002), then `imem_req` = 0. Raising `if_ready` resumes at 0x0004 with no loss or duplication.
- **Redirect during 3-wait fetch:** redirect to 0x0100 while a request to 0x0006 is outstanding → the ack for 0x0006 is discarded, next `imem_addr` = 0x0100, and the first `if_pc` after the flush is 0x0100.
- **Redirect coincident with ack:** redirect to 0x0200 in the ack cycle → the acked word is never presented, and `imem_addr` = 0x0200 next cycle.
- **Double redirect in DISCARD:** redirect to 0x0300, then to 0x0400 before the ack → only 0x0400 is fetched; no 0x0300 entry appears.
- **Wrap and reset:** redirect to 0xFFFE → 0xFFFE is followed by 0x0000. Asserting `rst` mid-request → `imem_req` = 0 immediately, `if_valid` = 0, and after release the first fetch is at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request channel, redirect input and
// the {pc, instr} channel toward decode, plus the fetch FSM state for checkers.
interface instr_fetch_unit_if #(
   parameter int PC_WIDTH = 16
);
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_ack;
   logic [15:0]         imem_rdata;
   logic                redirect;
   logic [PC_WIDTH-1:0] redirect_pc;
   logic                if_valid;
   logic                if_ready;
   logic [15:0]         if_instr;
   logic [3:0]          if_op_code;
   logic [PC_WIDTH-1:0] if_pc;
   logic [1:0]          fsm_state;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect, redirect_pc,
      output if_valid, if_instr, if_op_code, if_pc,
      input  if_ready,
      output fsm_state
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect, redirect_pc,
      input  if_valid, if_instr, if_op_code, if_pc,
      output if_ready,
      input  fsm_state
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding imem reads
// and buffers returned words in a shift-style prefetch FIFO for decode.
module instr_fetch_unit #(
   parameter int                  PC_WIDTH   = 16,
   parameter int                  FIFO_DEPTH = 2,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
   input logic               clk,
   input logic               rst,
   instr_fetch_unit_if.master bus
);
   // Handshakes: imem_req stays high with a stable imem_addr until imem_ack;
   // decode takes the head when if_valid && if_ready in the same cycle.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t              state, state_next;
   logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_next;
   logic [PC_WIDTH-1:0] addr_q, addr_next;
   logic                req_q;
   logic [CW-1:0]       count, count_next, wr_idx;
   logic [PC_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
   logic [15:0]         fifo_instr [FIFO_DEPTH];
   logic                valid_q;
   logic                push, pop, flush, space;

   always_comb begin
      flush = bus.redirect;
      push  = (state == S_WAIT) && bus.imem_ack && !bus.redirect;
      pop   = valid_q && bus.if_ready;
      count_next = count;
      if (flush)
         count_next = '0;
      else if (push && !pop)
         count_next = count + CW'(1);
      else if (pop && !push)
         count_next = count - CW'(1);
      // Entry 0 is always the head, so a pop shifts before the push lands.
      wr_idx = pop ? count - CW'(1) : count;
      space  = count_next < CW'(FIFO_DEPTH);
   end

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      addr_next     = addr_q;
      unique case (state)
         S_IDLE: begin
            if (bus.redirect) begin
               fetch_pc_next = bus.redirect_pc;
               addr_next     = bus.redirect_pc;
               state_next    = S_WAIT;
            end else if (space) begin
               addr_next  = fetch_pc;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.redirect) begin
               fetch_pc_next = bus.redirect_pc;
               if (bus.imem_ack)
                  addr_next = bus.redirect_pc;
               else
                  state_next = S_DISCARD;
            end else if (bus.imem_ack) begin
               fetch_pc_next = fetch_pc + PC_WIDTH'(2);
               addr_next     = fetch_pc + PC_WIDTH'(2);
               if (!space)
                  state_next = S_IDLE;
            end
         end
         S_DISCARD: begin
            // The stale request must still complete before a new one goes out.
            if (bus.redirect) begin
               fetch_pc_next = bus.redirect_pc;
               if (bus.imem_ack) begin
                  addr_next  = bus.redirect_pc;
                  state_next = S_WAIT;
               end
            end else if (bus.imem_ack) begin
               addr_next  = fetch_pc;
               state_next = S_WAIT;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         addr_q   <= RESET_PC;
         req_q    <= 1'b0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         addr_q   <= addr_next;
         req_q    <= (state_next != S_IDLE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else begin
         count   <= count_next;
         valid_q <= (count_next != '0);
         if (!flush) begin
            if (pop) begin
               for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                  fifo_pc[i]    <= fifo_pc[i+1];
                  fifo_instr[i] <= fifo_instr[i+1];
               end
            end
            if (push) begin
               for (int i = 0; i < FIFO_DEPTH; i++) begin
                  if (wr_idx == CW'(i)) begin
                     fifo_pc[i]    <= addr_q;
                     fifo_instr[i] <= bus.imem_rdata;
                  end
               end
            end
         end
      end
   end

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = addr_q;
   assign bus.if_valid   = valid_q;
   assign bus.if_pc      = fifo_pc[0];
   assign bus.if_instr   = fifo_instr[0];
   assign bus.if_op_code = fifo_instr[0][15:12];
   assign bus.fsm_state  = state;
endmodule
